// File: rtl/xor_checksum_4bit_pkg.sv
// rtl/xor_checksum_4bit_pkg.sv - shared constants and state encoding for the nibble checksum
// Purpose: nibble width, default frame geometry and FSM state encoding shared by
//          xor_checksum_4bit and its xor_4bit combine element.
// Ports:   none (package)
package xor_checksum_4bit_pkg;

  localparam int NIBBLE_W      = 4;
  localparam int DEF_FRAME_LEN = 8;
  localparam int DEF_CNT_W     = 4;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

endpackage

// File: rtl/xor_checksum_4bit_comb.sv
// rtl/xor_checksum_4bit_comb.sv - xor_4bit combine element
// Purpose: purely combinational 4-bit XOR, z = x ^ y.
// Ports:   x, y  in  NIBBLE_W  operands
//          z     out NIBBLE_W  result
module xor_4bit
  import xor_checksum_4bit_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  output logic [NIBBLE_W-1:0] z
);

  assign z = x ^ y;

endmodule

// File: rtl/xor_checksum_4bit.sv
// rtl/xor_checksum_4bit.sv - streaming XOR-fold nibble checksum with word count
// Purpose: folds a frame of 4-bit words (closed by in_last or FRAME_LEN words) into
//          one registered {out_sum, out_count} result on a valid/ready output port.
// Ports:   clk, rst (sync, active-high)
//          in_valid/in_ready/in_data[3:0]/in_last   word stream in
//          out_valid/out_ready/out_sum[3:0]/out_count[CNT_W-1:0]   result out
module xor_checksum_4bit
  import xor_checksum_4bit_pkg::*;
#(
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NIBBLE_W-1:0] in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NIBBLE_W-1:0] out_sum,
  output logic [CNT_W-1:0]    out_count
);

  localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);

  state_t              state;
  state_t              state_next;
  logic [NIBBLE_W-1:0] acc;
  logic [NIBBLE_W-1:0] acc_next;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_inc;
  logic                accept;
  logic                close;
  logic                out_fire;

  xor_4bit u_comb (
    .z (acc_next),
    .x (acc),
    .y (in_data)
  );

  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    in_ready   = (state == ST_ACCUM) && !rst;
    accept     = in_valid && in_ready;
    // in_last on the FRAME_LEN-th word still yields exactly one close
    close      = accept && (in_last || (cnt_inc == FRAME_LEN_C));
    out_fire   = (state == ST_DONE) && out_valid && out_ready;
    state_next = state;
    case (state)
      ST_ACCUM: if (close)    state_next = ST_DONE;
      ST_DONE:  if (out_fire) state_next = ST_ACCUM;
      default:                state_next = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_ACCUM;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
    end else begin
      if (accept) begin
        if (close) begin
          out_sum   <= acc_next;
          out_count <= cnt_inc;
          out_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= acc_next;
          cnt <= cnt_inc;
        end
      end
      // accept and out_fire are mutually exclusive: they need different states
      if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_xor_checksum_4bit.sv
// tb/tb_xor_checksum_4bit.sv - scoreboard bench for xor_checksum_4bit
module tb_xor_checksum_4bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_sum;
  logic [3:0] out_count;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  logic [7:0] sb_q[$];   // expected {sum, count}
  int         hs_cyc[$]; // cycle of each output handshake

  xor_checksum_4bit #(.FRAME_LEN(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: sample at negedge, a handshake happens on the following posedge
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      hs_cyc.push_back(cycle);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got sum=%0h count=%0d expected none", out_sum, out_count);
      end else begin
        logic [7:0] e;
        e = sb_q.pop_front();
        chk("out_sum", {4'h0, out_sum}, {4'h0, e[7:4]});
        chk("out_count", {4'h0, out_count}, {4'h0, e[3:0]});
      end
    end
  end

  task automatic send(input logic [3:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", 8'd0, 8'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      n++;
      @(posedge clk);
    end
    #1;
    chk("drain", 8'(sb_q.size()), 8'd0);
  endtask

  initial begin
    int base;
    rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; in_last = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {7'd0, in_ready}, 8'd0);
    @(negedge clk);
    chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_out_sum", {4'd0, out_sum}, 8'd0);
    chk("rst_out_count", {4'd0, out_count}, 8'd0);
    @(posedge clk); #1; rst = 1'b0;

    // T1: 5,2,7,12(last) -> 1100, count 4, valid one cycle after closing beat
    sb_q.push_back({4'b1100, 4'd4});
    send(4'd5, 1'b0); send(4'd2, 1'b0); send(4'd7, 1'b0);
    chk("t1_pre_valid", {7'd0, out_valid}, 8'd0);
    send(4'd12, 1'b1);
    chk("t1_latency_valid", {7'd0, out_valid}, 8'd1);
    drain();

    // T2: eight 15s close by count; 9th word stalls while result pending
    out_ready = 1'b0;
    sb_q.push_back({4'b0000, 4'd8});
    for (int i = 0; i < 8; i++) send(4'd15, 1'b0);
    in_valid = 1'b1; in_data = 4'd3;
    @(negedge clk);
    chk("t2_stall_in_ready", {7'd0, in_ready}, 8'd0);
    chk("t2_out_valid", {7'd0, out_valid}, 8'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    drain();

    // T3: 10,9(last) held while out_ready low; beats during DONE ignored
    out_ready = 1'b0;
    sb_q.push_back({4'b0011, 4'd2});
    send(4'd10, 1'b0); send(4'd9, 1'b1);
    in_valid = 1'b1; in_data = 4'd5; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_hold_sum", {4'd0, out_sum}, 8'h03);
      chk("t3_hold_count", {4'd0, out_count}, 8'd2);
      chk("t3_in_ready", {7'd0, in_ready}, 8'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_in_ready_after", {7'd0, in_ready}, 8'd1);
    drain();

    // T4: single word 10 with last
    sb_q.push_back({4'b1010, 4'd1});
    send(4'd10, 1'b1);
    drain();

    // T5: partial frame discarded by reset
    send(4'd5, 1'b0); send(4'd2, 1'b0); send(4'd7, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_no_output", {7'd0, out_valid}, 8'd0);
    sb_q.push_back({4'b1001, 4'd1});
    send(4'd9, 1'b1);
    drain();

    // T6: back-to-back frames with out_ready high -> one bubble
    base = hs_cyc.size();
    sb_q.push_back({4'b0000, 4'd2});
    sb_q.push_back({4'b1111, 4'd1});
    send(4'd0, 1'b0); send(4'd0, 1'b1); send(4'd15, 1'b1);
    drain();
    if (hs_cyc.size() == base + 2)
      chk("t6_spacing", 8'(hs_cyc[base+1] - hs_cyc[base]), 8'd2);
    else
      chk("t6_handshakes", 8'(hs_cyc.size() - base), 8'd2);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
